jt10_dac_ser: RTL

- Output-side consumer of the FM/ADPCM mixer. Captures the signed 16-bit left/right mix once per sample period, on the accumulator `zero` strobe.
- Converts each channel to the YM3016 floating-point word: 10-bit mantissa, 3-bit exponent.
- Shifts both words out LSB-first on a serial DAC interface (bck, so, sh1, sh2).
- Sits between the mixer and the board/emulated YM3016 DAC path, running in the FM clock domain.

---
 rtl/jt10_dac_ser.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/jt10_dac_ser.sv
// jt10_dac_ser: latches the stereo mix on the accumulator zero strobe, converts each
// channel to YM3016 float (10-bit mantissa, 3-bit exponent) and shifts it out LSB-first.
module jt10_dac_ser #(
  parameter int PADBITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        zero,
  input  logic [15:0] left,
  input  logic [15:0] right,
  output logic        bck,
  output logic        so,
  output logic        sh1,
  output logic        sh2,
  output logic        busy,
  output logic        ovr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] hold_l_q, hold_l_d;
  logic [15:0] hold_r_q, hold_r_d;
  logic [15:0] word_l_q, word_l_d;
  logic [15:0] word_r_q, word_r_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic        busy_q, busy_d;
  logic        bck_q, bck_d;
  logic        so_q, so_d;
  logic        sh1_q, sh1_d;
  logic        sh2_q, sh2_d;
  logic        load_s;
  logic [3:0]  bit_idx_s;

  // Smallest shift that makes the sample fit 10-bit signed; exponent is shift + 1.
  function automatic logic [15:0] to_float(input logic [15:0] x);
    logic [15:0] shifted;
    logic [2:0]  s;
    logic [9:0]  mant;
    s = 3'd6;
    for (int i = 6; i >= 0; i--) begin
      shifted = $signed(x) >>> i;
      s = (shifted[15:9] == {7{shifted[9]}}) ? 3'(i) : s;
    end
    shifted = $signed(x) >>> s;
    mant    = shifted[9:0];
    return 16'({s + 3'd1, mant}) << PADBITS;
  endfunction

  assign bit_idx_s = cnt_q[4:1];

  // Next-state: frame sequencing, sample capture and registered serial outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    word_l_d = word_l_q;
    word_r_d = word_r_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    load_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 6'd0;
        if (pend_q) begin
          state_d = ST_LEFT;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEFT: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = ST_RIGHT;
        end else begin
          state_d = ST_LEFT;
        end
      end
      ST_RIGHT: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = ST_LEFT;
          load_s  = pend_q;
        end else begin
          state_d = ST_RIGHT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 6'd0;
      end
    endcase

    // Without a pending sample the previous words simply repeat.
    if (load_s) begin
      word_l_d = to_float(hold_l_q);
      word_r_d = to_float(hold_r_q);
    end else begin
      word_l_d = word_l_q;
      word_r_d = word_r_q;
    end

    // A capture on the reload tick wins over the clear: it becomes next frame's sample.
    if (zero) begin
      hold_l_d = left;
      hold_r_d = right;
      pend_d   = 1'b1;
      ovr_d    = ovr_q | pend_q;
    end else begin
      pend_d   = pend_q & ~load_s;
    end

    busy_d = (state_d != ST_IDLE);

    if (state_q == ST_IDLE) begin
      bck_d = 1'b0;
      so_d  = 1'b0;
      sh1_d = 1'b0;
      sh2_d = 1'b0;
    end else begin
      bck_d = cnt_q[0];
      if (cnt_q[0]) begin
        so_d = so_q;
      end else if (cnt_q[5]) begin
        so_d = word_r_q[bit_idx_s];
      end else begin
        so_d = word_l_q[bit_idx_s];
      end
      sh1_d = (cnt_q[5:1] == 5'd15);
      sh2_d = (cnt_q[5:1] == 5'd31);
    end
  end

  // State registers, advancing only on clk_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      hold_l_q <= 16'd0;
      hold_r_q <= 16'd0;
      word_l_q <= 16'd0;
      word_r_q <= 16'd0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
      bck_q    <= 1'b0;
      so_q     <= 1'b0;
      sh1_q    <= 1'b0;
      sh2_q    <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      word_l_q <= word_l_d;
      word_r_q <= word_r_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
      bck_q    <= bck_d;
      so_q     <= so_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
    end
  end

  assign bck  = bck_q;
  assign so   = so_q;
  assign sh1  = sh1_q;
  assign sh2  = sh2_q;
  assign busy = busy_q;
  assign ovr  = ovr_q;

endmodule
